// File: rtl/dynamic_adder_pkg.sv
// Shared types and default parameter values for the dynamic adder requester.
package dynamic_adder_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_TIMEOUT     = 16;
  localparam int DEF_MIN_WAIT    = 3;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/dynamic_adder_requester_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
  end

  // NOTE: reset lives inside the clocked branch, so it is synchronous and
  // only takes effect on a rising clk edge.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dynamic_adder_requester.sv
// Initiator side of the dynamic adder handshake: launches one addition at a
// time, waits for the adder's R (or a timeout) and presents the result.
module dynamic_adder_requester
  import dynamic_adder_pkg::*;
#(
  parameter  int WIDTH       = DEF_WIDTH,
  parameter  int TIMEOUT     = DEF_TIMEOUT,
  parameter  int MIN_WAIT    = DEF_MIN_WAIT,
  parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int CW          = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [WIDTH-1:0] add_A,
  output logic [WIDTH-1:0] add_B,
  output logic             add_Cin,
  output logic             add_F,
  output logic             add_request,
  input  logic             add_R,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_Cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_timeout,
  output logic [CW-1:0]    res_cycles
);

  state_e           state_q, state_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             timeout_q, timeout_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic             r_sync;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_r (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (add_R),
    .q     (r_sync)
  );

  // NOTE: every *_d takes its hold value first so no path through the case
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    timeout_d  = timeout_q;
    cycles_d   = cycles_q;

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          cin_d   = op_cin;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // R before MIN_WAIT may still be the previous operation's completion.
        if (r_sync && (wait_cnt_q >= CW'(MIN_WAIT))) begin
          sum_d     = add_sum;
          cout_d    = add_Cout;
          cycles_d  = wait_cnt_q;
          timeout_d = 1'b0;
          state_d   = HOLD;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          sum_d     = add_sum;
          cout_d    = add_Cout;
          cycles_d  = CW'(TIMEOUT);
          timeout_d = 1'b1;
          state_d   = HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      timeout_q  <= timeout_d;
      cycles_q   <= cycles_d;
    end
  end

  assign op_ready    = (state_q == IDLE);
  assign add_F       = (state_q == LAUNCH);
  assign add_request = (state_q == LAUNCH) || (state_q == WAIT);
  assign res_valid   = (state_q == HOLD);
  assign add_A       = a_q;
  assign add_B       = b_q;
  assign add_Cin     = cin_q;
  assign res_sum     = sum_q;
  assign res_cout    = cout_q;
  assign res_timeout = timeout_q;
  assign res_cycles  = cycles_q;

endmodule

// File: tb/tb_dynamic_adder_requester.sv
// Directed bench for dynamic_adder_requester with a hand-driven adder model.
module tb_dynamic_adder_requester;

  localparam int WIDTH       = 32;
  localparam int TIMEOUT     = 16;
  localparam int MIN_WAIT    = 3;
  localparam int SYNC_STAGES = 2;
  localparam int CW          = $clog2(TIMEOUT + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_cin;
  logic [WIDTH-1:0] add_A, add_B;
  logic             add_Cin, add_F, add_request;
  logic             add_R;
  logic [WIDTH-1:0] add_sum;
  logic             add_Cout;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout, res_timeout;
  logic [CW-1:0]    res_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dynamic_adder_requester #(
    .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .MIN_WAIT(MIN_WAIT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_A(add_A), .add_B(add_B), .add_Cin(add_Cin),
    .add_F(add_F), .add_request(add_request),
    .add_R(add_R), .add_sum(add_sum), .add_Cout(add_Cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout),
    .res_timeout(res_timeout), .res_cycles(res_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from IDLE and follow it to res_valid. add_R is
  // raised in WAIT cycle r_at (0-based); r_at < 0 leaves add_R untouched.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic [WIDTH-1:0] sum,
                        input logic cout, input int r_at,
                        output int waits, output int f_cnt,
                        output logic got_valid, output logic [WIDTH-1:0] a_seen);
    op_a = a; op_b = b; op_cin = cin; op_valid = 1'b1;
    add_sum = sum; add_Cout = cout;
    step();
    op_valid  = 1'b0;
    f_cnt     = add_F ? 1 : 0;
    a_seen    = add_A;
    waits     = 0;
    got_valid = 1'b0;
    for (int i = 0; i < 40 && !got_valid; i++) begin
      step();
      if (res_valid) got_valid = 1'b1;
      else begin
        if (add_F) f_cnt++;
        if (i == r_at) add_R = 1'b1;
        waits++;
      end
    end
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    add_R     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
    add_R = 1'b0; add_sum = '0; add_Cout = 1'b0; res_ready = 1'b0;
    step(); step();
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %b want 1", op_ready); end
    checks++; if (add_request !== 1'b0) begin errors++; $display("FAIL reset_add_request: got %b want 0", add_request); end
    checks++; if (add_F !== 1'b0) begin errors++; $display("FAIL reset_add_F: got %b want 0", add_F); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (add_A !== 32'h0) begin errors++; $display("FAIL reset_add_A: got %h want 0", add_A); end
    checks++; if (res_cycles !== CW'(0)) begin errors++; $display("FAIL reset_res_cycles: got %0d want 0", res_cycles); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_normal_add();
    int waits, f_cnt; logic got; logic [WIDTH-1:0] a_seen;
    run_op(32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1, waits, f_cnt, got, a_seen);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL normal_valid: got %b want 1", got); end
    checks++; if (f_cnt != 1) begin errors++; $display("FAIL normal_f_pulse: got %0d want 1", f_cnt); end
    checks++; if (waits != 4) begin errors++; $display("FAIL normal_wait_cycles: got %0d want 4", waits); end
    checks++; if (a_seen !== 32'h5) begin errors++; $display("FAIL normal_add_A: got %h want 5", a_seen); end
    checks++; if (add_B !== 32'h3) begin errors++; $display("FAIL normal_add_B: got %h want 3", add_B); end
    checks++; if (res_sum !== 32'h8) begin errors++; $display("FAIL normal_sum: got %h want 8", res_sum); end
    checks++; if (res_cout !== 1'b0) begin errors++; $display("FAIL normal_cout: got %b want 0", res_cout); end
    checks++; if (res_cycles !== CW'(3)) begin errors++; $display("FAIL normal_cycles: got %0d want 3", res_cycles); end
    checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL normal_timeout: got %b want 0", res_timeout); end
    checks++; if (add_request !== 1'b0) begin errors++; $display("FAIL normal_hold_request: got %b want 0", add_request); end
    release_result();
    checks++; if (res_valid !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL normal_release: got valid=%b ready=%b want 0/1", res_valid, op_ready); end
  endtask

  task automatic test_carry_out();
    int waits, f_cnt; logic got; logic [WIDTH-1:0] a_seen;
    res_ready = 1'b1;  // asserted early: must not skip or shorten HOLD
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 5, waits, f_cnt, got, a_seen);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL carry_valid: got %b want 1", got); end
    checks++; if (res_sum !== 32'h0) begin errors++; $display("FAIL carry_sum: got %h want 0", res_sum); end
    checks++; if (res_cout !== 1'b1) begin errors++; $display("FAIL carry_cout: got %b want 1", res_cout); end
    checks++; if (res_cycles !== CW'(7)) begin errors++; $display("FAIL carry_cycles: got %0d want 7", res_cycles); end
    step();
    res_ready = 1'b0; add_R = 1'b0;
    checks++; if (res_valid !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL carry_release: got valid=%b ready=%b want 0/1", res_valid, op_ready); end
  endtask

  task automatic test_timeout();
    int waits, f_cnt; logic got; logic [WIDTH-1:0] a_seen;
    run_op(32'h1234, 32'h1, 1'b1, 32'hDEAD_BEEF, 1'b1, -1, waits, f_cnt, got, a_seen);
    checks++; if (waits != 16) begin errors++; $display("FAIL timeout_wait_cycles: got %0d want 16", waits); end
    checks++; if (res_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", res_timeout); end
    checks++; if (res_cycles !== CW'(16)) begin errors++; $display("FAIL timeout_cycles: got %0d want 16", res_cycles); end
    checks++; if (res_sum !== 32'hDEAD_BEEF) begin errors++; $display("FAIL timeout_sum: got %h want deadbeef", res_sum); end
    checks++; if (add_Cin !== 1'b1) begin errors++; $display("FAIL timeout_add_Cin: got %b want 1", add_Cin); end
    release_result();
  endtask

  task automatic test_r_at_timeout();
    int waits, f_cnt; logic got; logic [WIDTH-1:0] a_seen;
    // R raised in WAIT cycle 13 reaches r_sync at wait_cnt 15 == TIMEOUT-1.
    run_op(32'h7, 32'h9, 1'b0, 32'h10, 1'b0, 13, waits, f_cnt, got, a_seen);
    checks++; if (res_timeout !== 1'b0) begin errors++; $display("FAIL r_vs_timeout_flag: got %b want 0", res_timeout); end
    checks++; if (res_cycles !== CW'(15)) begin errors++; $display("FAIL r_vs_timeout_cycles: got %0d want 15", res_cycles); end
    checks++; if (res_sum !== 32'h10) begin errors++; $display("FAIL r_vs_timeout_sum: got %h want 10", res_sum); end
    release_result();
  endtask

  task automatic test_stale_r();
    int waits, f_cnt; logic got; logic [WIDTH-1:0] a_seen;
    add_R = 1'b1;
    step(); step(); step();
    run_op(32'h20, 32'h22, 1'b1, 32'h43, 1'b0, -1, waits, f_cnt, got, a_seen);
    checks++; if (waits != 4) begin errors++; $display("FAIL stale_wait_cycles: got %0d want 4", waits); end
    checks++; if (res_cycles !== CW'(MIN_WAIT)) begin errors++; $display("FAIL stale_cycles: got %0d want 3", res_cycles); end
    checks++; if (res_sum !== 32'h43) begin errors++; $display("FAIL stale_sum: got %h want 43", res_sum); end
    release_result();
  endtask

  task automatic test_backpressure();
    int waits, f_cnt, bad; logic got; logic [WIDTH-1:0] a_seen;
    run_op(32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 1, waits, f_cnt, got, a_seen);
    op_a = 32'hAAAA_0001; op_b = 32'h2; op_cin = 1'b0; op_valid = 1'b1;
    add_R = 1'b0; add_sum = 32'h5555_5555;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid !== 1'b1 || op_ready !== 1'b0 || res_sum !== 32'h30 ||
          res_cycles !== CW'(3) || add_A !== 32'h10) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL backpressure_stable: got %0d bad cycles want 0", bad); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL backpressure_still_valid: got %b want 1", res_valid); end
    release_result();
    checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL backpressure_idle: got ready=%b valid=%b want 1/0", op_ready, res_valid); end
    checks++; if (add_A !== 32'h10) begin errors++; $display("FAIL backpressure_no_early_accept: got %h want 10", add_A); end
    run_op(32'hAAAA_0001, 32'h2, 1'b0, 32'hAAAA_0003, 1'b0, 2, waits, f_cnt, got, a_seen);
    checks++; if (a_seen !== 32'hAAAA_0001) begin errors++; $display("FAIL backpressure_new_accept: got %h want aaaa0001", a_seen); end
    checks++; if (res_sum !== 32'hAAAA_0003 || res_cycles !== CW'(4)) begin errors++; $display("FAIL backpressure_new_result: got %h/%0d want aaaa0003/4", res_sum, res_cycles); end
    release_result();
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    op_a = 32'h77; op_b = 32'h11; op_cin = 1'b0; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    step(); step(); step();  // now in WAIT with wait_cnt 2
    checks++; if (add_request !== 1'b1) begin errors++; $display("FAIL midreset_in_wait: got %b want 1", add_request); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (op_ready !== 1'b1 || add_request !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_idle: got ready=%b req=%b valid=%b want 1/0/0", op_ready, add_request, res_valid);
    end
    checks++; if (add_A !== 32'h0) begin errors++; $display("FAIL midreset_add_A: got %h want 0", add_A); end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (res_valid !== 1'b0 || op_ready !== 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_result: got %0d bad cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_normal_add();
    test_carry_out();
    test_timeout();
    test_r_at_timeout();
    test_stale_r();
    test_backpressure();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dynamic_adder_requester.md
Name: dynamic_adder_requester

Overview:
- Initiator side of the dynamic adder handshake.
- Accepts one operand pair at a time from an upstream valid/ready stream and drives A/B/Cin/F/request into the dynamic adder.
- Waits for the adder's completion signal R, then captures sum/Cout and the measured completion time.
- Presents the result on a downstream valid/ready stream. A timeout guards against an R that never asserts.

Parameters:
- WIDTH, 32, operand/sum width.
- TIMEOUT, 16, max WAIT cycles before a forced capture; must be ≥ MIN_WAIT+1.
- MIN_WAIT, 3, WAIT cycles during which synchronized R is ignored; masks stale R from the previous operation. Must be ≥ SYNC_STAGES+1.
- SYNC_STAGES, 2, flop stages on incoming add_R.
- CW, $clog2(TIMEOUT+1), cycle-count width (derived, not overridable).

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- op_valid  in  1  upstream operand valid
- op_ready  out  1  upstream ready
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- op_cin  in  1  carry in
- add_A  out  WIDTH  to adder A
- add_B  out  WIDTH  to adder B
- add_Cin  out  1  to adder Cin
- add_F  out  1  "first" pulse, restarts adder timer
- add_request  out  1  request to adder
- add_R  in  1  adder ready (treated as asynchronous)
- add_sum  in  WIDTH  adder sum (valid when R)
- add_Cout  in  1  adder carry out
- res_valid  out  1  result valid
- res_ready  in  1  downstream ready
- res_sum  out  WIDTH  captured sum
- res_cout  out  1  captured carry
- res_timeout  out  1  result forced by timeout
- res_cycles  out  CW  WAIT cycles to completion

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, rst_n; sampled on the rising clk edge only.
- Reset: state=IDLE. All outputs 0 except op_ready=1. Sync flops 0, wait_cnt 0. Reset mid-operation abandons the operation; no result is produced.
- add_R passes through SYNC_STAGES flops to give r_sync; only r_sync is used.
- IDLE:
  - op_ready=1, add_request=0, res_valid=0.
  - On op_valid&op_ready: register op_a/op_b/op_cin into add_A/add_B/add_Cin, then go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - add_F=1, add_request=1, op_ready=0.
  - wait_cnt<=0. Next state WAIT.
- WAIT:
  - add_F=0, add_request=1.
  - Each cycle, evaluate in priority order:
    1. r_sync==1 and wait_cnt≥MIN_WAIT: capture add_sum/add_Cout into res_sum/res_cout; res_cycles<=wait_cnt; res_timeout<=0; go to HOLD.
    2. Else if wait_cnt==TIMEOUT-1: capture add_sum/add_Cout anyway; res_cycles<=TIMEOUT; res_timeout<=1; go to HOLD.
    3. Else wait_cnt<=wait_cnt+1.
  - R and timeout in the same cycle: R wins, res_timeout=0.
  - r_sync high while wait_cnt<MIN_WAIT is ignored.
- HOLD:
  - res_valid=1, add_request=0, op_ready=0.
  - res_* stable until res_ready. On res_ready go to IDLE; res_valid falls next cycle.
  - res_* keep their last value in IDLE; they are only meaningful with res_valid.
- add_A/add_B/add_Cin: stable from LAUNCH through HOLD; change only on an IDLE accept.
- No pipelining: one operation in flight. Accept-to-res_valid latency = 2 + captured wait_cnt + 1 cycles (IDLE accept, LAUNCH, WAIT cycles, HOLD).
- res_ready asserted early (outside HOLD) has no effect.
- op_valid is ignored outside IDLE; op_* must be held by upstream until accepted.

Decomposition:
- Package dynamic_adder_pkg:
  - state enum {IDLE, LAUNCH, WAIT, HOLD} (2 bits).
  - Default-value localparams for WIDTH/TIMEOUT/MIN_WAIT/SYNC_STAGES.
- Sub-module sync_bit (parameter STAGES; clk, rst_n, d, q): synchronizer for add_R.
- FSM, counter and capture registers live in the top module.

Test Plan:
- Normal add: op_a=0x00000005, op_b=0x00000003, op_cin=0. Model drives add_sum=0x00000008 and add_R=1 from the 2nd WAIT cycle. Expected: capture at wait_cnt=3; res_sum=0x8, res_cout=0, res_cycles=3, res_timeout=0; add_F high exactly 1 cycle.
- Carry out: op_a=0xFFFFFFFF, op_b=0x00000001, op_cin=0. Model returns sum=0, Cout=1 with R at WAIT cycle 5. Expected: res_sum=0x00000000, res_cout=1, res_cycles=7.
- Timeout: model never raises add_R. Expected: res_valid after 16 WAIT cycles; res_timeout=1, res_cycles=16.
- Stale R: add_R held 1 through LAUNCH and the whole operation. Expected: capture at wait_cnt=MIN_WAIT=3, never earlier.
- Backpressure: res_ready=0 for 10 cycles in HOLD. Expected: res_valid and res_* stable; op_ready=0; new op_valid not accepted until 1 cycle after res_ready.
- Reset mid-WAIT: rst_n=0 for 1 cycle at wait_cnt=2. Expected: next cycle IDLE, op_ready=1, add_request=0, res_valid=0, no result emitted.
